mcu_pixel_bridge: RTL
=====================

# mcu_pixel_bridge

Parametrised MCU-to-framebuffer bridge. It sits between the 8-bit MCU register bus and the memory manager's pixel write port. Unlike the single-shot pixel interface, it synchronises every bus field into the `clock` domain, buffers pixel writes in a FIFO, optionally auto-increments coordinates with raster wrap, and supports register read-back with a status/overflow register. Memory-side requests drain the FIFO one pixel at a time through the existing request/complete handshake.

## Interface
- X_WIDTH, 9, width of the X coordinate (must be 9..16)
- Y_WIDTH, 8, width of the Y coordinate (must be ≤ 8)
- DATA_WIDTH, 8, pixel colour width (≤ 8; bus-visible bits only)
- X_LIMIT, 320, pixels per line; auto-increment wraps X at X_LIMIT-1
- Y_LIMIT, 240, lines; auto-increment wraps Y at Y_LIMIT-1
- FIFO_DEPTH, 4, pending pixel writes; power of two, ≥ 2
- clock  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state
- memoryXCoord  out  X_WIDTH  X of pixel being written
- memoryYCoord  out  Y_WIDTH  Y of pixel being written
- memoryWriteData  out  DATA_WIDTH  pixel colour
- memoryWriteRequest  out  1  write request to memory manager
- memoryWriteComplete  in  1  memory manager acknowledge, one-cycle pulse
- mpuChipSelect  in  1  MCU chip select, active high, asynchronous
- mpuWriteEnable  in  1  0 = write cycle, 1 = read cycle (while selected)
- mpuRegisterSelect  in  3  register address
- mpuDataBus  inout  8  MCU data bus

## Operation
- Register map: 0 X[7:0]; 1 X[X_WIDTH-1:8]; 2 Y; 3 DATA (write pushes pixel); 4 CONTROL (bit0 autoInc, RW; bit1 write-1 clears overflow, reads 0); 5 STATUS (RO: bit0 empty, bit1 full, bit2 overflow, bit3 autoInc); 6,7 reserved (writes ignored, read 0). Unused upper bits read 0.
- Write strobe = mpuChipSelect & !mpuWriteEnable. Strobe, mpuRegisterSelect and mpuDataBus are sampled each clock into stage1 and then stage2. A commit occurs when stage2.strobe=1 and stage1.strobe=0. The commit uses the stage2 select and data.
- Read: mpuDataBus is driven combinationally from the selected register while mpuChipSelect & mpuWriteEnable & reset high. Otherwise it is high-Z. The bridge never drives the bus during a write strobe.
- DATA commit, FIFO not full: push {X, Y, data}. If autoInc=1, advance coordinates: if X = X_LIMIT-1 then X←0 and Y←(Y = Y_LIMIT-1 ? 0 : Y+1); otherwise X←X+1. If autoInc=0, coordinates are unchanged.
- DATA commit, FIFO full: the pixel is dropped, overflow sets (sticky), and coordinates are not advanced, so the MCU can retry. Full is evaluated on the pre-edge count; a pop in the same cycle does not rescue the push.
- X/Y register writes take effect immediately for the next DATA commit. Entries already queued keep their captured coordinates.
- Drain FSM:
  - IDLE: FIFO non-empty → load outputs from head, go to REQUEST.
  - REQUEST: memoryWriteRequest=1; on memoryWriteComplete pop head, go to RELEASE.
  - RELEASE: request=0 for exactly one cycle → IDLE.
- FIFO count width is log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leaves the count unchanged.

## Timing
- Reset (asynchronous, while reset=0): all memory outputs 0; memoryWriteRequest 0; X, Y, autoInc and overflow 0; FIFO empty; synchroniser stages 0; bus high-Z; FSM in IDLE.
- Reset mid-request drops memoryWriteRequest immediately and flushes the FIFO.
- MCU constraints: strobe high ≥ 3 clocks; data and select stable from strobe rise until ≥ 1 clock after strobe fall; strobe low ≥ 3 clocks between writes.
- Latency: let edge k be the first edge sampling the strobe low. Commit happens at k+1; memoryWriteRequest rises at edge k+2 when the FIFO was empty and the FSM was in IDLE.
- memoryWriteComplete is ignored outside REQUEST. Back-to-back queued entries are spaced by REQUEST + RELEASE + IDLE, so a new request rises at least 2 clocks after the previous complete.
- Memory outputs are held stable for the entire REQUEST state.

## Test plan
- Reset then single write: X=0x1FF via regs 0/1, Y=0x02, DATA=0x03 → one request with memoryXCoord=0x1FF, memoryYCoord=0x02, memoryWriteData=0x03; ack after 5 clocks → request low for one cycle; STATUS reads 0x01.
- Auto-increment wrap: autoInc=1, X=318, Y=239; three DATA writes 0xA0, 0xA1, 0xA2 → memory sees (318,239), (319,239), (0,0); X reads back 1.
- Overflow: hold memoryWriteComplete low and issue 6 DATA writes with FIFO_DEPTH=4 → STATUS=0x06 (full, overflow); then complete 4 acks → exactly 4 pixels written in order, dropped writes leave X unadvanced; CONTROL bit1 write → overflow 0.
- Read-back: write Y=0x55, then read reg 2 → bus=0x55 while selected and high-Z after deselect; reads of reg 6 → 0x00.
- Simultaneous push/pop: FIFO holding 1 entry, DATA commit in the same cycle as memoryWriteComplete → count stays 1; order is preserved.
- Reset mid-request: assert reset while request is high with 3 queued → request low immediately, STATUS=0x01 after release, no further requests.

Source files
------------

// File: rtl/mcu_pixel_bridge_if.sv
// Signal bundle between the bridge, the MCU register bus controls and the memory manager write port.
// The tri-state MCU data bus stays a plain module port so it resolves at the top level.
interface mcu_pixel_bridge_if #(
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8,
    parameter int DATA_WIDTH = 8
);
    logic [X_WIDTH-1:0]    memoryXCoord;
    logic [Y_WIDTH-1:0]    memoryYCoord;
    logic [DATA_WIDTH-1:0] memoryWriteData;
    logic                  memoryWriteRequest;
    logic                  memoryWriteComplete;
    logic                  mpuChipSelect;
    logic                  mpuWriteEnable;
    logic [2:0]            mpuRegisterSelect;

    modport master (
        output memoryXCoord,
        output memoryYCoord,
        output memoryWriteData,
        output memoryWriteRequest,
        input  memoryWriteComplete,
        input  mpuChipSelect,
        input  mpuWriteEnable,
        input  mpuRegisterSelect
    );

    modport slave (
        input  memoryXCoord,
        input  memoryYCoord,
        input  memoryWriteData,
        input  memoryWriteRequest,
        output memoryWriteComplete,
        output mpuChipSelect,
        output mpuWriteEnable,
        output mpuRegisterSelect
    );
endinterface

// File: rtl/mcu_pixel_bridge.sv
// MCU register bus to framebuffer write port bridge: synchronised register writes, pixel FIFO
// with optional raster auto-increment, register read-back, and a one-pixel-at-a-time drain FSM.
module mcu_pixel_bridge #(
    parameter int X_WIDTH    = 9,
    parameter int Y_WIDTH    = 8,
    parameter int DATA_WIDTH = 8,
    parameter int X_LIMIT    = 320,
    parameter int Y_LIMIT    = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    mcu_pixel_bridge_if.master  bus_if,
    inout  wire  [7:0]          mpuDataBus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = X_WIDTH + Y_WIDTH + DATA_WIDTH;
    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_LIMIT - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_RELEASE
    } state_t;

    // Two-stage sampling of the asynchronous MCU bus
    logic       strobe_s1_reg, strobe_s2_reg;
    logic [2:0] sel_s1_reg, sel_s2_reg;
    logic [7:0] data_s1_reg, data_s2_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            strobe_s1_reg <= 1'b0;
            strobe_s2_reg <= 1'b0;
            sel_s1_reg    <= '0;
            sel_s2_reg    <= '0;
            data_s1_reg   <= '0;
            data_s2_reg   <= '0;
        end else begin
            strobe_s1_reg <= bus_if.mpuChipSelect & ~bus_if.mpuWriteEnable;
            sel_s1_reg    <= bus_if.mpuRegisterSelect;
            data_s1_reg   <= mpuDataBus;
            strobe_s2_reg <= strobe_s1_reg;
            sel_s2_reg    <= sel_s1_reg;
            data_s2_reg   <= data_s1_reg;
        end
    end

    logic commit;
    logic wr_x_lo, wr_x_hi, wr_y, wr_data, wr_ctrl;

    assign commit  = strobe_s2_reg & ~strobe_s1_reg;
    assign wr_x_lo = commit && (sel_s2_reg == 3'd0);
    assign wr_x_hi = commit && (sel_s2_reg == 3'd1);
    assign wr_y    = commit && (sel_s2_reg == 3'd2);
    assign wr_data = commit && (sel_s2_reg == 3'd3);
    assign wr_ctrl = commit && (sel_s2_reg == 3'd4);

    // FIFO bookkeeping
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          fifo_full, fifo_empty;
    logic          push, pop;

    state_t state_reg, state_next;
    logic   load;

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    // Full is judged on the pre-edge count, so a same-cycle pop never rescues a push
    assign push = wr_data & ~fifo_full;
    assign pop  = (state_reg == ST_REQUEST) & bus_if.memoryWriteComplete;

    // Register file
    logic [X_WIDTH-1:0] x_reg, x_next;
    logic [Y_WIDTH-1:0] y_reg, y_next;
    logic               auto_inc_reg, auto_inc_next;
    logic               overflow_reg, overflow_next;

    always_comb begin
        x_next        = x_reg;
        y_next        = y_reg;
        auto_inc_next = auto_inc_reg;
        overflow_next = overflow_reg;
        if (wr_x_lo) x_next[7:0] = data_s2_reg;
        if (wr_x_hi) x_next[X_WIDTH-1:8] = data_s2_reg[X_WIDTH-9:0];
        if (wr_y)    y_next = data_s2_reg[Y_WIDTH-1:0];
        if (wr_ctrl) begin
            auto_inc_next = data_s2_reg[0];
            if (data_s2_reg[1]) overflow_next = 1'b0;
        end
        if (wr_data && fifo_full) overflow_next = 1'b1;
        if (push && auto_inc_reg) begin
            if (x_reg == X_LAST) begin
                x_next = '0;
                y_next = (y_reg == Y_LAST) ? '0 : y_reg + Y_WIDTH'(1);
            end else begin
                x_next = x_reg + X_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg        <= '0;
            y_reg        <= '0;
            auto_inc_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            x_reg        <= x_next;
            y_reg        <= y_next;
            auto_inc_reg <= auto_inc_next;
            overflow_reg <= overflow_next;
        end
    end

    // Pixel storage: no reset so it maps onto distributed/block RAM
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr_reg] <= {x_reg, y_reg, data_s2_reg[DATA_WIDTH-1:0]};
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Drain FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (bus_if.memoryWriteComplete) state_next = ST_RELEASE;
            end
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Memory-side outputs are only loaded in IDLE, so they hold for all of REQUEST
    logic [X_WIDTH-1:0]    out_x_reg;
    logic [Y_WIDTH-1:0]    out_y_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_x_reg    <= '0;
            out_y_reg    <= '0;
            out_data_reg <= '0;
        end else if (load) begin
            {out_x_reg, out_y_reg, out_data_reg} <= fifo_mem[rd_ptr_reg];
        end
    end

    assign bus_if.memoryXCoord       = out_x_reg;
    assign bus_if.memoryYCoord       = out_y_reg;
    assign bus_if.memoryWriteData    = out_data_reg;
    assign bus_if.memoryWriteRequest = (state_reg == ST_REQUEST);

    // Read-back path
    logic [7:0] rd_data;
    logic       bus_drive;

    always_comb begin
        rd_data = '0;
        case (bus_if.mpuRegisterSelect)
            3'd0:    rd_data = x_reg[7:0];
            3'd1:    rd_data = 8'(x_reg[X_WIDTH-1:8]);
            3'd2:    rd_data = 8'(y_reg);
            3'd4:    rd_data = {7'd0, auto_inc_reg};
            3'd5:    rd_data = {4'd0, auto_inc_reg, overflow_reg, fifo_full, fifo_empty};
            default: rd_data = '0;
        endcase
    end

    assign bus_drive  = bus_if.mpuChipSelect & bus_if.mpuWriteEnable & reset;
    assign mpuDataBus = bus_drive ? rd_data : 8'hzz;

endmodule
